// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
//
// Bundles every non-clock signal of the boot loader. It carries the incoming
// program byte stream, the instruction-memory write port and the core
// control/status lines.
//
// Parameters:
//   IMEM_AW    - instruction-memory word-address width
//
// Signals:
//   rx_data    - stream byte
//   rx_valid   - rx_data valid
//   rx_ready   - loader accepts a byte (transfer on rx_valid && rx_ready)
//   imem_we    - one-cycle instruction-memory write strobe
//   imem_addr  - instruction-memory word address
//   imem_wdata - assembled little-endian 32-bit word
//   cpu_nreset - active-low reset to the core
//   done       - image loaded, core released
//   error      - sticky load failure
//
// Modports:
//   slave  - the loader: consumes the byte stream, drives everything else
//   master - the environment: drives the byte stream, observes the rest
// ---------------------------------------------------------------------------
interface boot_loader_if #(
  parameter int IMEM_AW = 10
);

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               cpu_nreset;
  logic               done;
  logic               error;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output cpu_nreset,
    output done,
    output error
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  cpu_nreset,
    input  done,
    input  error
  );

endinterface

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//
// Byte-stream program loader placed in front of the CPU core. The core is
// held in reset while a framed program image arrives over an 8-bit
// valid/ready stream. The image is written into instruction memory as
// little-endian 32-bit words from word address 0, and the core is then
// released. A malformed image parks the loader in a sticky error state
// with the core still in reset.
//
// Frame: "BOOT" (42 4F 4F 54), word count N (2 bytes, little-endian),
//        N*4 payload bytes, then an optional XOR checksum byte.
//
// Parameters:
//   IMEM_AW - instruction-memory word-address width (image <= 2^IMEM_AW
//             words); must not exceed 16
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - boot_loader_if.slave: byte stream in, imem write port and core
//          control/status out
//
// Configuration macro:
//   BOOT_LOADER_CHECKSUM_EN - when defined, an XOR-of-payload checksum byte
//                             follows the payload and is verified before
//                             the core is released.
// ---------------------------------------------------------------------------
module boot_loader #(
  parameter int IMEM_AW = 10
) (
  input  logic         clk,
  input  logic         rst,
  boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    INIT,
    MAGIC,
    LEN,
    DATA,
    CSUM,
    DRAIN,
    RUN,
    ERR
  } state_t;

  // Largest legal word count, kept one bit wider than the address so that
  // 2^IMEM_AW itself is representable and the length compare never truncates.
  localparam logic [16:0]        MAX_WORDS = 17'd1 << IMEM_AW;
  localparam logic [IMEM_AW-1:0] ONE_WORD  = 1;

  // Where the FSM goes once the last payload byte has been taken.
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = CSUM;
`else
  localparam state_t AFTER_PAYLOAD = DRAIN;
`endif

  state_t             state;
  state_t             next_state;

  logic [1:0]         magic_idx;
  logic [1:0]         magic_idx_next;
  logic               len_hi_phase;
  logic [7:0]         len_lo;
  logic [15:0]        len;
  logic [15:0]        len_full;
  logic [1:0]         byte_cnt;
  logic [IMEM_AW-1:0] word_idx;
  logic [23:0]        word_buf;
  logic               last_word;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  logic               rx_ready_c;
  logic               accept;

  logic               imem_we_q;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic [31:0]        imem_wdata_q;

  logic               run_c;
  logic               err_c;

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h42;
      2'd1:    return 8'h4F;
      2'd2:    return 8'h4F;
      default: return 8'h54;
    endcase
  endfunction

  // The loader only listens while it is still parsing the frame; in every
  // other state rx_valid is ignored and nothing is consumed.
  assign rx_ready_c = (state == MAGIC) || (state == LEN) ||
                      (state == DATA)  || (state == CSUM);
  assign accept     = bus.rx_valid && rx_ready_c;

  // The complete length as it appears on the handshake of the high byte.
  assign len_full   = {bus.rx_data, len_lo};

  // The word currently being assembled is the final one of the image.
  assign last_word  = (({1'b0, len} - 17'd1) ==
                       {{(17 - IMEM_AW){1'b0}}, word_idx});

  // State register. Asynchronous reset parks the loader in INIT, which also
  // pulls cpu_nreset low immediately through the status decode below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and status decode. The magic hunt restarts on a mismatch;
  // since 0x42 only appears at the head of "BOOT", a mismatching 0x42 is
  // itself the start of a new candidate and moves the hunt to index 1.
  always_comb begin
    next_state     = state;
    magic_idx_next = magic_idx;
    run_c          = 1'b0;
    err_c          = 1'b0;

    unique case (state)
      INIT: begin
        next_state = MAGIC;
      end

      MAGIC: begin
        if (accept) begin
          if (bus.rx_data == magic_byte(magic_idx)) begin
            if (magic_idx == 2'd3) begin
              next_state     = LEN;
              magic_idx_next = 2'd0;
            end else begin
              magic_idx_next = magic_idx + 2'd1;
            end
          end else begin
            magic_idx_next = (bus.rx_data == 8'h42) ? 2'd1 : 2'd0;
          end
        end
      end

      LEN: begin
        if (accept && len_hi_phase) begin
          if ({1'b0, len_full} > MAX_WORDS) begin
            next_state = ERR;
          end else if (len_full == 16'd0) begin
            next_state = AFTER_PAYLOAD;
          end else begin
            next_state = DATA;
          end
        end
      end

      DATA: begin
        if (accept && (byte_cnt == 2'd3) && last_word) begin
          next_state = AFTER_PAYLOAD;
        end
      end

`ifdef BOOT_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          next_state = (bus.rx_data == csum) ? DRAIN : ERR;
        end
      end
`else
      CSUM: begin
        next_state = ERR;
      end
`endif

      // One spare cycle so the final imem write strobe has completed before
      // the core is let out of reset.
      DRAIN: begin
        next_state = RUN;
      end

      RUN: begin
        run_c = 1'b1;
      end

      ERR: begin
        err_c = 1'b1;
      end

      default: begin
        next_state = ERR;
      end
    endcase
  end

  // Frame datapath: length capture, word assembly, the write strobe and the
  // running checksum. Bytes arrive least-significant first, so each new byte
  // is shifted in from the top and the fourth byte completes the word.
  // The word index stops on the last word so the address never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      magic_idx    <= 2'd0;
      len_hi_phase <= 1'b0;
      len_lo       <= 8'h00;
      len          <= 16'h0000;
      byte_cnt     <= 2'd0;
      word_idx     <= '0;
      word_buf     <= 24'h000000;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h00000000;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum         <= 8'h00;
`endif
    end else begin
      imem_we_q <= 1'b0;
      magic_idx <= magic_idx_next;

      if (accept) begin
        case (state)
          LEN: begin
            if (!len_hi_phase) begin
              len_lo       <= bus.rx_data;
              len_hi_phase <= 1'b1;
            end else begin
              len <= len_full;
            end
          end

          DATA: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.rx_data;
`endif
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= word_idx;
              imem_wdata_q <= {bus.rx_data, word_buf};
              if (!last_word) begin
                word_idx <= word_idx + ONE_WORD;
              end
            end else begin
              word_buf <= {bus.rx_data, word_buf[23:8]};
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

  assign bus.rx_ready   = rx_ready_c;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_nreset = run_c;
  assign bus.done       = run_c;
  assign bus.error      = err_c;

endmodule

// File: tb/tb_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_loader
//
// Self-checking bench for boot_loader. A behavioural model keeps the list of
// bytes the loader should have accepted and re-derives, from the frame
// format alone, whether more bytes are wanted, whether the image is complete
// or malformed, and which word each accepted byte completes. A compare
// process checks the outputs against the model on every falling edge; a few
// directed frames also carry hand-computed literal expectations.
// Honours BOOT_LOADER_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_boot_loader;

  localparam int AW       = 10;
  localparam int MS_MORE  = 0;
  localparam int MS_DONE  = 1;
  localparam int MS_ERR   = 2;
  localparam int TIMEOUT  = 50;

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;

  boot_loader_if #(.IMEM_AW(AW)) bus ();

  boot_loader #(.IMEM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit stall  = 1'b0;

  // Model state: accepted bytes, position just after "BOOT", INIT cycle
  // pending, and whether the one drain cycle after completion has elapsed.
  logic [7:0]    acc[$];
  int            magic_pos    = -1;
  bit            init_pending = 1'b1;
  bit            drained      = 1'b0;
  logic          exp_we       = 1'b0;
  logic [AW-1:0] exp_addr     = '0;
  logic [31:0]   exp_data     = 32'h0;

  // Write log seen on the DUT bus, for the literal checks.
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wordCount();
    return int'({acc[magic_pos + 1], acc[magic_pos]});
  endfunction

  // Frame status from the accepted bytes alone.
  function automatic int modelStatus();
    int         hdr;
    int         n;
    int         need;
    logic [7:0] x;
    if (magic_pos < 0 || acc.size() < magic_pos + 2) return MS_MORE;
    n = wordCount();
    if (n > (1 << AW)) return MS_ERR;
    hdr  = magic_pos + 2;
    need = hdr + 4 * n + CSUM_BYTES;
    if (acc.size() < need) return MS_MORE;
    if (CSUM_BYTES == 1) begin
      x = 8'h00;
      for (int i = hdr; i < hdr + 4 * n; i++) x = x ^ acc[i];
      if (x !== acc[need - 1]) return MS_ERR;
    end
    return MS_DONE;
  endfunction

  // Record one accepted byte. The magic hunt is equivalent to finding the
  // first occurrence of "BOOT" in the stream, because 0x42 only opens it.
  task automatic modelAccept(input logic [7:0] b);
    int k;
    int p;
    acc.push_back(b);
    k = acc.size();
    if (magic_pos < 0) begin
      if (k >= 4 && acc[k-4] == 8'h42 && acc[k-3] == 8'h4F &&
          acc[k-2] == 8'h4F && acc[k-1] == 8'h54) begin
        magic_pos = k;
      end
      return;
    end
    p = (k - 1) - (magic_pos + 2);
    if (p >= 0 && (p % 4) == 3 && p < 4 * wordCount()) begin
      exp_we   = 1'b1;
      exp_addr = AW'(p / 4);
      exp_data = {acc[k-1], acc[k-2], acc[k-3], acc[k-4]};
    end
  endtask

  // Model update on every rising edge or reset assertion.
  initial begin
    int st;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        acc.delete();
        magic_pos    = -1;
        init_pending = 1'b1;
        drained      = 1'b0;
        exp_we       = 1'b0;
      end else begin
        exp_we = 1'b0;
        if (init_pending) begin
          init_pending = 1'b0;
        end else begin
          st = modelStatus();
          if (st == MS_DONE) drained = 1'b1;
          else if (st == MS_MORE && bus.rx_valid) modelAccept(bus.rx_data);
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    int  st;
    bit  run;
    forever begin
      @(negedge clk);
      st  = modelStatus();
      run = (st == MS_DONE) && drained;
      checkOutput("rx_ready", 32'(bus.rx_ready),
                  32'(!rst && !init_pending && st == MS_MORE));
      checkOutput("imem_we", 32'(bus.imem_we), 32'(exp_we));
      if (exp_we) begin
        checkOutput("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
        checkOutput("imem_wdata", bus.imem_wdata, exp_data);
      end
      checkOutput("done", 32'(bus.done), 32'(run));
      checkOutput("cpu_nreset", 32'(bus.cpu_nreset), 32'(run));
      checkOutput("error", 32'(bus.error), 32'(st == MS_ERR));
      if (bus.imem_we === 1'b1) begin
        log_addr.push_back(bus.imem_addr);
        log_data.push_back(bus.imem_wdata);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearLog();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic holdValid(input int n);
    repeat (n) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      idle(1);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst          = 1'b1;
    bus.rx_valid = 1'($urandom_range(1, 0));
    idle(2);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    stall        = 1'b0;
    clearLog();
    idle(1);
  endtask

  // Present one byte after a random number of idle cycles and hold it until
  // the handshake; returns one time unit after the accepting edge.
  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int gaps;
    bit hs;
    if (stall) return;
    gaps = (gapMax == 0) ? 0 : int'($urandom_range(gapMax, 0));
    repeat (gaps) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      idle(1);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int t = 0; t < TIMEOUT; t++) begin
      @(negedge clk);
      hs = bus.rx_ready;
      idle(1);
      if (hs) begin
        bus.rx_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    stall        = 1'b1;
    bus.rx_valid = 1'b0;
    $display("[TB] FAIL handshake_timeout: got no rx_ready expected accept within %0d cycles", TIMEOUT);
  endtask

  task automatic applyStimulus(input byte_q_t frame, input int gapMax);
    foreach (frame[i]) sendByte(frame[i], gapMax);
  endtask

  function automatic byte_q_t buildFrame(input int n);
    byte_q_t    f;
    logic [7:0] b;
    logic [7:0] x;
    f = '{8'h42, 8'h4F, 8'h4F, 8'h54};
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x = x ^ b;
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    if ($urandom_range(3, 0) == 0) x = x ^ 8'h01;
    f.push_back(x);
`endif
    return f;
  endfunction

  initial begin
    byte_q_t frame;

    $display("[TB] boot_loader bench start");
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset hold with rx_valid asserted.
    #1;
    rst          = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h42;
    idle(3);
    checkOutput("reset_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("reset_cpu_nreset", 32'(bus.cpu_nreset), 32'd0);
    checkOutput("reset_imem_addr", 32'(bus.imem_addr), 32'd0);
    checkOutput("reset_imem_wdata", bus.imem_wdata, 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_error", 32'(bus.error), 32'd0);
    checkOutput("reset_write_count", 32'(log_addr.size()), 32'd0);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    idle(2);

    // Single word, back-to-back.
    $display("[TB] single word");
    clearLog();
    frame = '{8'h42, 8'h4F, 8'h4F, 8'h54, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    frame.push_back(8'h13);
`endif
    applyStimulus(frame, 0);
    checkOutput("single_done_drain", 32'(bus.done), 32'd0);
    idle(1);
    checkOutput("single_done", 32'(bus.done), 32'd1);
    checkOutput("single_cpu_nreset", 32'(bus.cpu_nreset), 32'd1);
    checkOutput("single_model_status", 32'(modelStatus()), 32'(MS_DONE));
    checkOutput("single_write_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) begin
      checkOutput("single_addr", 32'(log_addr[0]), 32'd0);
      checkOutput("single_data", log_data[0], 32'h00000013);
    end
    holdValid(3);

    // Magic resync with random gaps.
    $display("[TB] magic resync");
    doReset();
    frame = '{8'h42, 8'h42, 8'h4F, 8'h4F, 8'h54, 8'h02, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef BOOT_LOADER_CHECKSUM_EN
    frame.push_back(8'h88);
`endif
    applyStimulus(frame, 2);
    idle(3);
    checkOutput("resync_write_count", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() >= 2) begin
      checkOutput("resync_addr0", 32'(log_addr[0]), 32'd0);
      checkOutput("resync_data0", log_data[0], 32'h44332211);
      checkOutput("resync_addr1", 32'(log_addr[1]), 32'd1);
      checkOutput("resync_data1", log_data[1], 32'h88776655);
    end
    checkOutput("resync_error", 32'(bus.error), 32'd0);
    checkOutput("resync_done", 32'(bus.done), 32'd1);

    // Over-length image: one word past the memory size.
    $display("[TB] over-length");
    doReset();
    frame = '{8'h42, 8'h4F, 8'h4F, 8'h54, 8'h01, 8'h04};
    applyStimulus(frame, 1);
    checkOutput("overlen_error", 32'(bus.error), 32'd1);
    checkOutput("overlen_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("overlen_cpu_nreset", 32'(bus.cpu_nreset), 32'd0);
    holdValid(4);
    checkOutput("overlen_error_sticky", 32'(bus.error), 32'd1);
    checkOutput("overlen_write_count", 32'(log_addr.size()), 32'd0);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Checksum off by one.
    $display("[TB] checksum error");
    doReset();
    frame = '{8'h42, 8'h4F, 8'h4F, 8'h54, 8'h01, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    applyStimulus(frame, 1);
    checkOutput("csum_error_edge", 32'(bus.error), 32'd1);
    idle(3);
    checkOutput("csum_write_count", 32'(log_addr.size()), 32'd1);
    checkOutput("csum_error", 32'(bus.error), 32'd1);
    checkOutput("csum_done", 32'(bus.done), 32'd0);
`endif

    // Reset in the middle of a four-word load, then a full reload.
    $display("[TB] mid-load reset");
    doReset();
    frame = buildFrame(4);
    frame = frame[0:13];
    applyStimulus(frame, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midload_cpu_nreset", 32'(bus.cpu_nreset), 32'd0);
    checkOutput("midload_rx_ready", 32'(bus.rx_ready), 32'd0);
    idle(2);
    rst = 1'b0;
    clearLog();
    idle(1);
    frame = '{8'h42, 8'h4F, 8'h4F, 8'h54, 8'h01, 8'h00, 8'h01, 8'h00, 8'hA5, 8'hA5};
`ifdef BOOT_LOADER_CHECKSUM_EN
    frame.push_back(8'h01);
`endif
    applyStimulus(frame, 1);
    idle(3);
    checkOutput("reload_write_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) begin
      checkOutput("reload_addr", 32'(log_addr[0]), 32'd0);
      checkOutput("reload_data", log_data[0], 32'hA5A50001);
    end
    checkOutput("reload_done", 32'(bus.done), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("run_reset_cpu_nreset", 32'(bus.cpu_nreset), 32'd0);
    checkOutput("run_reset_done", 32'(bus.done), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Empty image.
    $display("[TB] empty image");
    doReset();
    frame = '{8'h42, 8'h4F, 8'h4F, 8'h54, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    applyStimulus(frame, 0);
    idle(3);
    checkOutput("empty_done", 32'(bus.done), 32'd1);
    checkOutput("empty_write_count", 32'(log_addr.size()), 32'd0);

    // Largest legal image fills the whole memory.
    $display("[TB] full-size image");
    doReset();
    frame = buildFrame(1 << AW);
`ifdef BOOT_LOADER_CHECKSUM_EN
    frame[frame.size() - 1] = 8'h00;
    for (int i = 6; i < frame.size() - 1; i++) frame[frame.size() - 1] ^= frame[i];
`endif
    applyStimulus(frame, 0);
    idle(3);
    checkOutput("full_write_count", 32'(log_addr.size()), 32'(1 << AW));
    if (log_addr.size() == (1 << AW)) begin
      checkOutput("full_last_addr", 32'(log_addr[(1 << AW) - 1]), 32'((1 << AW) - 1));
    end
    checkOutput("full_done", 32'(bus.done), 32'd1);

    // Randomized frames with junk before the magic and random gaps.
    $display("[TB] random frames");
    for (int r = 0; r < 10; r++) begin
      doReset();
      repeat ($urandom_range(5, 0)) sendByte(8'($urandom), 1);
      frame = buildFrame(int'($urandom_range(8, 0)));
      applyStimulus(frame, int'($urandom_range(2, 0)));
      idle(3);
      holdValid(3);
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
